// File: rtl/modport_mem.sv
// Memory side of the memory/test interface: 2^ADDR_W x DATA_W storage with
// clocked writes, combinational gated read, and asynchronous clear on reset.
module modport_mem #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Reset wipes every word so a pending write in the reset cycle is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (write) begin
         mem_q[addr] <= data_in;
      end
   end

   assign data_out = read ? mem_q[addr] : '0;

endmodule

// File: tb/tb_modport_mem.sv
// Randomized and directed check of modport_mem against an array-based
// reference memory held in the bench.
`timescale 1ns/1ns
module tb_modport_mem;

   logic       clk;
   logic       rst_n;
   logic       read;
   logic       write;
   logic [4:0] addr;
   logic [7:0] data_in;
   logic [7:0] data_out;

   logic       clk_run;
   int         n_edges;
   int         n_chk;
   int         n_err;
   logic [7:0] ref_mem [32];

   modport_mem #(.ADDR_W(5), .DATA_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .read     (read),
      .write    (write),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out)
   );

   // Clock can be parked low so the async reset can be observed edge-free.
   initial begin
      clk = 1'b0;
      forever begin
         #10;
         if (clk_run || clk) clk = ~clk;
      end
   end

   always @(posedge clk) n_edges++;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic ref_clear();
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
   endtask

   // One access: drive, sample 7 ns later, then advance past the edge.
   task automatic apply(input logic w, input logic r, input logic [4:0] a,
                        input logic [7:0] d, input string tag);
      write   = w;
      read    = r;
      addr    = a;
      data_in = d;
      #7;
      chk(tag, data_out, r ? ref_mem[a] : 8'h00);
      @(posedge clk);
      if (w) ref_mem[a] = d;
      #1;
   endtask

   initial begin
      int e0;
      logic [4:0] ra;
      logic [7:0] rd;
      n_chk = 0;
      n_err = 0;
      n_edges = 0;
      clk_run = 1'b1;
      rst_n = 1'b0;
      read = 1'b0;
      write = 1'b0;
      addr = '0;
      data_in = '0;
      ref_clear();
      #25 rst_n = 1'b1;
      @(posedge clk);
      #1;

      apply(1'b0, 1'b1, 5'd0,  8'h00, "rst_a0");
      apply(1'b0, 1'b1, 5'd15, 8'h00, "rst_a15");
      apply(1'b0, 1'b1, 5'd31, 8'h00, "rst_a31");

      for (int i = 0; i < 32; i++) apply(1'b1, 1'b0, 5'(i), 8'(i + 16), "pat_wr");
      for (int i = 0; i < 32; i++) begin
         write = 1'b0; read = 1'b1; addr = 5'(i);
         #7;
         chk("pat_rd", data_out, 8'(i + 16));
         @(posedge clk);
         #1;
      end

      apply(1'b1, 1'b0, 5'd3, 8'hA5, "rdis_wr");
      read = 1'b0; write = 1'b0; addr = 5'd3;
      #7 chk("rdis_off", data_out, 8'h00);
      read = 1'b1;
      #1 chk("rdis_on", data_out, 8'hA5);
      @(posedge clk);
      #1;

      apply(1'b1, 1'b0, 5'd7, 8'h11, "rw_setup");
      write = 1'b1; read = 1'b1; addr = 5'd7; data_in = 8'h22;
      #7 chk("rw_before", data_out, 8'h11);
      @(posedge clk);
      ref_mem[7] = 8'h22;
      #1 chk("rw_after", data_out, 8'h22);

      apply(1'b1, 1'b0, 5'd9, 8'h3C, "nsw_setup");
      for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 5'd9, (i % 2 == 0) ? 8'hFF : 8'h00, "nsw_idle");
      apply(1'b0, 1'b1, 5'd9, 8'h00, "nsw_keep");

      for (int i = 0; i < 300; i++) begin
         ra = 5'($urandom_range(0, 31));
         rd = 8'($urandom_range(0, 255));
         apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rd, "rand");
      end

      // A write pending when reset falls must be lost.
      write = 1'b1; read = 1'b0; addr = 5'd5; data_in = 8'h77;
      #3 rst_n = 1'b0;
      ref_clear();
      @(posedge clk);
      #3 rst_n = 1'b1;
      write = 1'b0;
      @(posedge clk);
      #1;
      apply(1'b0, 1'b1, 5'd5, 8'h00, "rstwr_lost");
      apply(1'b1, 1'b1, 5'd5, 8'h5A, "post_rst_wr");
      apply(1'b0, 1'b1, 5'd5, 8'h00, "post_rst_rd");

      for (int i = 0; i < 32; i++) apply(1'b1, 1'b0, 5'(i), 8'hFF, "fill_ff");
      apply(1'b0, 1'b1, 5'd31, 8'h00, "fill_chk");
      clk_run = 1'b0;
      #12;
      e0 = n_edges;
      rst_n = 1'b0;
      ref_clear();
      for (int i = 0; i < 32; i++) begin
         read = 1'b1; write = 1'b0; addr = 5'(i);
         #1 chk("async_clr", data_out, ref_mem[i]);
      end
      chk("async_noedge", 8'(n_edges - e0), 8'h00);
      rst_n = 1'b1;
      #3 clk_run = 1'b1;
      @(posedge clk);
      #1;
      apply(1'b0, 1'b1, 5'd20, 8'h00, "async_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
